// File: rtl/turn_executor_if.sv
// turn_executor_if: command, sensor and motor signals between the CPU-side controller and turn_executor
interface turn_executor_if;
  logic       start;
  logic [4:0] path_len;
  logic [2:0] sensors;
  logic [1:0] turn_flag;
  logic       node_flag;
  logic       node_changed;
  logic [1:0] left_dir;
  logic [1:0] right_dir;
  logic       arrived;
  logic       fault;
  logic [4:0] node_count;
  modport master (
    output start, path_len, sensors, turn_flag,
    input  node_flag, node_changed, left_dir, right_dir, arrived, fault, node_count
  );
  modport slave (
    input  start, path_len, sensors, turn_flag,
    output node_flag, node_changed, left_dir, right_dir, arrived, fault, node_count
  );
endinterface

// File: rtl/turn_executor.sv
// turn_executor: line follower that detects nodes, hands off to path_mapping, executes turns and stops on arrival
module turn_executor #(
  parameter int DEBOUNCE    = 8,
  parameter int CROSS_TICKS = 600000,
  parameter int TURN_WAIT   = 16,
  parameter int TURN_MIN    = 400000,
  parameter int UTURN_MIN   = 900000,
  parameter int TURN_MAX    = 3000000,
  parameter int LOST_TICKS  = 1500000,
  parameter int CW          = 24
) (
  input logic clk_3125KHz,
  input logic reset,
  turn_executor_if.slave bus
);
  localparam int DW = $clog2(DEBOUNCE + 1);
  localparam logic [1:0] STOP = 2'b00, FWD = 2'b01, REV = 2'b10;
  typedef enum logic [2:0] {IDLE, FOLLOW, CROSS, WAIT_TURN, SPIN, ARRIVED, FAULT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] timer_q, timer_d, timer_inc;
  logic [DW-1:0] deb_q, deb_d;
  logic [4:0] cnt_q, cnt_d;
  logic [1:0] left_q, left_d, right_q, right_d;
  logic flag_q, flag_d, uturn_q, uturn_d, arrived_q, arrived_d, fault_q, fault_d;
  logic spin_ok;
  assign timer_inc = &timer_q ? timer_q : timer_q + 1'b1;
  assign spin_ok = timer_q >= (uturn_q ? CW'(UTURN_MIN) : CW'(TURN_MIN));
  // One shared timer: lost-line count in FOLLOW, time since the node pulse in CROSS/WAIT_TURN, spin time in SPIN
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    deb_d = '0;
    cnt_d = cnt_q;
    left_d = left_q;
    right_d = right_q;
    flag_d = 1'b0;
    uturn_d = uturn_q;
    if (!bus.start) begin
      state_d = IDLE;
      left_d = STOP;
      right_d = STOP;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          timer_d = '0;
          state_d = bus.path_len == 5'd0 ? ARRIVED : FOLLOW;
        end
        FOLLOW: begin
          deb_d = bus.sensors == 3'b111 ? deb_q + 1'b1 : '0;
          timer_d = bus.sensors == 3'b000 ? timer_inc : '0;
          if (bus.sensors == 3'b111 && deb_d == DW'(DEBOUNCE)) begin
            deb_d = '0;
            flag_d = 1'b1;
            cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
            state_d = CROSS;
            timer_d = '0;
            left_d = FWD;
            right_d = FWD;
          end else if (bus.sensors == 3'b000) begin
            if (timer_inc >= CW'(LOST_TICKS)) begin
              state_d = FAULT;
              left_d = STOP;
              right_d = STOP;
            end
          end else begin
            left_d = bus.sensors[2] & ~bus.sensors[0] ? STOP : FWD;
            right_d = bus.sensors[0] & ~bus.sensors[2] ? STOP : FWD;
          end
        end
        CROSS: begin
          timer_d = timer_inc;
          if (timer_q >= CW'(CROSS_TICKS - 1)) begin
            state_d = cnt_q == bus.path_len ? ARRIVED : WAIT_TURN;
            left_d = STOP;
            right_d = STOP;
          end
        end
        WAIT_TURN: begin
          timer_d = timer_inc;
          if (timer_q >= CW'(TURN_WAIT)) begin
            state_d = bus.turn_flag == 2'd0 ? FOLLOW : SPIN;
            timer_d = '0;
            uturn_d = bus.turn_flag == 2'd2;
            left_d = bus.turn_flag == 2'd3 ? REV : FWD;
            right_d = bus.turn_flag[0] ^ bus.turn_flag[1] ? REV : FWD;
          end
        end
        SPIN: begin
          timer_d = timer_inc;
          if (bus.sensors[1] && spin_ok) begin
            state_d = FOLLOW;
            timer_d = '0;
            left_d = FWD;
            right_d = FWD;
          end else if (timer_inc >= CW'(TURN_MAX)) begin
            state_d = FAULT;
            left_d = STOP;
            right_d = STOP;
          end
        end
        default: begin
          left_d = STOP;
          right_d = STOP;
        end
      endcase
    end
    arrived_d = state_d == ARRIVED;
    fault_d = state_d == FAULT;
  end
  always_ff @(posedge clk_3125KHz) begin
    if (reset) begin
      state_q <= IDLE;
      timer_q <= '0;
      deb_q <= '0;
      cnt_q <= '0;
      left_q <= STOP;
      right_q <= STOP;
      flag_q <= 1'b0;
      uturn_q <= 1'b0;
      arrived_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      deb_q <= deb_d;
      cnt_q <= cnt_d;
      left_q <= left_d;
      right_q <= right_d;
      flag_q <= flag_d;
      uturn_q <= uturn_d;
      arrived_q <= arrived_d;
      fault_q <= fault_d;
    end
  end
  assign bus.node_flag = flag_q;
  assign bus.node_changed = flag_q;
  assign bus.left_dir = left_q;
  assign bus.right_dir = right_q;
  assign bus.arrived = arrived_q;
  assign bus.fault = fault_q;
  assign bus.node_count = cnt_q;
endmodule

// File: tb/tb_turn_executor.sv
// tb_turn_executor: scoreboard bench driving directed and random runs against a phase-level reference model
module tb_turn_executor;
  localparam int DEB = 8, CRS = 20, TW = 16, TMIN = 50, UMIN = 90, TMAX = 200, LOST = 40;
  localparam int P_IDLE = 0, P_FOL = 1, P_CROSS = 2, P_WAIT = 3, P_SPIN = 4, P_ARR = 5, P_FLT = 6;
  typedef struct packed {
    logic [1:0] l;
    logic [1:0] r;
    logic       flag;
    logic       arr;
    logic       flt;
    logic [4:0] cnt;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  turn_executor_if bus();
  turn_executor #(
    .DEBOUNCE(DEB), .CROSS_TICKS(CRS), .TURN_WAIT(TW), .TURN_MIN(TMIN),
    .UTURN_MIN(UMIN), .TURN_MAX(TMAX), .LOST_TICKS(LOST), .CW(24)
  ) dut (
    .clk_3125KHz(clk),
    .reset(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  exp_t q[$];
  exp_t pend, mon_e, mon_got;
  bit have_pend = 1'b0;
  int checks = 0, fails = 0, cyc = 0;
  int m_ph = P_IDLE, m_cnt = 0, m_run = 0, m_zero = 0, m_since = 0, m_spin = 0;
  logic [1:0] m_l = 2'b00, m_r = 2'b00;
  bit m_u = 1'b0, m_flag = 1'b0;
  logic cur_start = 1'b0;
  logic [4:0] cur_pl = 5'd0;
  logic [2:0] steer [6] = '{3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101};
  task automatic chk(input bit ok, input string what);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s cycle %0d: l=%b r=%b flag=%b chg=%b arr=%b flt=%b cnt=%0d", what, cyc,
               bus.left_dir, bus.right_dir, bus.node_flag, bus.node_changed, bus.arrived, bus.fault, bus.node_count);
    end
  endtask
  task automatic model(input logic rs, input logic st, input logic [4:0] pl, input logic [2:0] s, input logic [1:0] tf);
    m_flag = 1'b0;
    if (rs) begin
      m_ph = P_IDLE; m_cnt = 0; m_l = 2'b00; m_r = 2'b00;
    end else if (!st) begin
      m_ph = P_IDLE; m_l = 2'b00; m_r = 2'b00;
    end else begin
      case (m_ph)
        P_IDLE: begin
          m_cnt = 0; m_run = 0; m_zero = 0;
          m_ph = (pl == 5'd0) ? P_ARR : P_FOL;
        end
        P_FOL: begin
          if (s == 3'b111) begin
            m_zero = 0; m_run++; m_l = 2'b01; m_r = 2'b01;
            if (m_run == DEB) begin
              m_flag = 1'b1; m_run = 0; m_since = 0; m_ph = P_CROSS;
              m_cnt = (m_cnt < 31) ? m_cnt + 1 : 31;
            end
          end else if (s == 3'b000) begin
            m_run = 0; m_zero++;
            if (m_zero >= LOST) begin m_ph = P_FLT; m_l = 2'b00; m_r = 2'b00; end
          end else begin
            m_run = 0; m_zero = 0;
            m_l = (s == 3'b100 || s == 3'b110) ? 2'b00 : 2'b01;
            m_r = (s == 3'b001 || s == 3'b011) ? 2'b00 : 2'b01;
          end
        end
        P_CROSS: begin
          if (m_since == CRS - 1) begin
            m_ph = (m_cnt == int'(pl)) ? P_ARR : P_WAIT; m_l = 2'b00; m_r = 2'b00;
          end
          m_since++;
        end
        P_WAIT: begin
          if (m_since >= TW) begin
            m_spin = 0;
            case (tf)
              2'd0: begin m_ph = P_FOL; m_l = 2'b01; m_r = 2'b01; m_run = 0; m_zero = 0; end
              2'd1: begin m_ph = P_SPIN; m_l = 2'b01; m_r = 2'b10; m_u = 1'b0; end
              2'd2: begin m_ph = P_SPIN; m_l = 2'b01; m_r = 2'b10; m_u = 1'b1; end
              default: begin m_ph = P_SPIN; m_l = 2'b10; m_r = 2'b01; m_u = 1'b0; end
            endcase
          end
          m_since++;
        end
        P_SPIN: begin
          if (s[1] && m_spin >= (m_u ? UMIN : TMIN)) begin
            m_ph = P_FOL; m_l = 2'b01; m_r = 2'b01; m_run = 0; m_zero = 0;
          end else begin
            m_spin++;
            if (m_spin >= TMAX) begin m_ph = P_FLT; m_l = 2'b00; m_r = 2'b00; end
          end
        end
        default: begin m_l = 2'b00; m_r = 2'b00; end
      endcase
    end
  endtask
  task automatic step(input logic rs, input logic [2:0] s, input logic [1:0] tf);
    @(posedge clk);
    #1;
    if (have_pend) q.push_back(pend);
    rst = rs;
    bus.start = cur_start;
    bus.path_len = cur_pl;
    bus.sensors = s;
    bus.turn_flag = tf;
    model(rs, cur_start, cur_pl, s, tf);
    pend = '{l: m_l, r: m_r, flag: m_flag, arr: (m_ph == P_ARR), flt: (m_ph == P_FLT), cnt: m_cnt[4:0]};
    have_pend = 1'b1;
  endtask
  task automatic drv(input logic [2:0] s, input logic [1:0] tf);
    step(1'b0, s, tf);
  endtask
  task automatic node(input logic [1:0] tf);
    repeat (DEB) drv(3'b111, tf);
    repeat (CRS + 1) drv(3'b010, tf);
  endtask
  task automatic random_run();
    int seg;
    int budget;
    logic [2:0] pat;
    seg = 0;
    budget = 0;
    pat = 3'b010;
    cur_start = 1'b0;
    drv(3'b000, 2'd0);
    drv(3'b000, 2'd0);
    cur_pl = 5'($urandom_range(0, 4));
    cur_start = 1'b1;
    while (budget < 3000 && !(m_ph == P_ARR || m_ph == P_FLT)) begin
      int r;
      logic [2:0] s;
      logic [1:0] tf;
      logic rs;
      tf = 2'($urandom_range(0, 3));
      rs = ($urandom_range(0, 499) == 0);
      if (m_ph == P_FOL) begin
        if (seg == 0) begin
          r = $urandom_range(0, 9);
          if (r < 5) begin pat = steer[$urandom_range(0, 5)]; seg = $urandom_range(1, 4); end
          else if (r < 8) begin pat = 3'b111; seg = $urandom_range(DEB - 2, DEB + 3); end
          else if (r == 8) begin pat = 3'b000; seg = $urandom_range(1, 10); end
          else begin pat = 3'b000; seg = $urandom_range(LOST - 5, LOST + 3); end
        end
        s = pat;
        seg--;
      end else if (m_ph == P_SPIN) begin
        s = ($urandom_range(0, 7) == 0) ? 3'b010 : (3'($urandom_range(0, 7)) & 3'b101);
      end else begin
        s = 3'($urandom_range(0, 7));
      end
      step(rs, s, tf);
      budget++;
    end
    repeat (3) drv(3'($urandom_range(0, 7)), 2'd0);
  endtask
  always @(negedge clk) begin
    cyc++;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      mon_got = '{l: bus.left_dir, r: bus.right_dir, flag: bus.node_flag, arr: bus.arrived, flt: bus.fault, cnt: bus.node_count};
      checks++;
      if (mon_got !== mon_e || bus.node_changed !== mon_e.flag) begin
        fails++;
        $display("FAIL outputs cycle %0d: got l=%b r=%b flag=%b chg=%b arr=%b flt=%b cnt=%0d, expected l=%b r=%b flag=%b arr=%b flt=%b cnt=%0d",
                 cyc, mon_got.l, mon_got.r, mon_got.flag, bus.node_changed, mon_got.arr, mon_got.flt, mon_got.cnt,
                 mon_e.l, mon_e.r, mon_e.flag, mon_e.arr, mon_e.flt, mon_e.cnt);
      end
    end
  end
  initial begin
    bus.start = 1'b0;
    bus.path_len = 5'd0;
    bus.sensors = 3'b000;
    bus.turn_flag = 2'd0;
    step(1'b1, 3'b000, 2'd0);
    step(1'b1, 3'b000, 2'd0);
    @(negedge clk);
    #1;
    chk(bus.left_dir === 2'b00 && bus.right_dir === 2'b00 && bus.node_flag === 1'b0 && bus.node_changed === 1'b0 &&
        bus.arrived === 1'b0 && bus.fault === 1'b0 && bus.node_count === 5'd0, "reset state");
    cur_start = 1'b1;
    cur_pl = 5'd3;
    drv(3'b010, 2'd0);
    drv(3'b010, 2'd0);
    drv(3'b100, 2'd0);
    drv(3'b110, 2'd0);
    drv(3'b001, 2'd0);
    drv(3'b011, 2'd0);
    drv(3'b101, 2'd0);
    repeat (DEB - 1) drv(3'b111, 2'd0);
    drv(3'b010, 2'd0);
    node(2'd1);
    for (int i = 0; i < 70; i++) begin
      drv((i == 30 || i == 60) ? 3'b010 : 3'b000, 2'd3);
      if (i == 10) begin
        @(negedge clk);
        #1;
        chk(bus.left_dir === 2'b01 && bus.right_dir === 2'b10 && bus.fault === 1'b0, "expired wait right spin");
      end
    end
    drv(3'b010, 2'd0);
    node(2'd2);
    repeat (TMAX + 2) drv(3'b000, 2'd0);
    cur_start = 1'b0;
    repeat (3) drv(3'b010, 2'd0);
    cur_start = 1'b1;
    cur_pl = 5'd5;
    drv(3'b010, 2'd0);
    node(2'd3);
    repeat (10) drv(3'b000, 2'd0);
    step(1'b1, 3'b000, 2'd0);
    repeat (3) drv(3'b010, 2'd0);
    cur_start = 1'b0;
    drv(3'b010, 2'd0);
    cur_start = 1'b1;
    cur_pl = 5'd3;
    drv(3'b010, 2'd0);
    node(2'd0);
    drv(3'b010, 2'd0);
    node(2'd0);
    node(2'd0);
    repeat (5) drv(3'b010, 2'd0);
    cur_start = 1'b0;
    drv(3'b010, 2'd0);
    cur_start = 1'b1;
    cur_pl = 5'd2;
    drv(3'b010, 2'd0);
    repeat (LOST + 2) drv(3'b000, 2'd0);
    cur_start = 1'b0;
    drv(3'b010, 2'd0);
    cur_pl = 5'd0;
    cur_start = 1'b1;
    repeat (3) drv(3'b010, 2'd0);
    for (int run = 0; run < 25; run++) random_run();
    cur_start = 1'b0;
    repeat (3) drv(3'b010, 2'd0);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/turn_executor.md
Name: turn_executor

Overview:
- Motion sequencer downstream of path_mapping. Consumes `turn_flag` (0 straight, 1 right, 2 U-turn, 3 left, in the N=0/E=1/S=2/W=3 heading convention) and the digitised line-sensor triple.
- Follows the line, detects nodes, and pulses `node_flag`/`node_changed` back to path_mapping. It then waits for the new `turn_flag`, executes the turn, and resumes following.
- Stops with `arrived` after `path_len` nodes.

Parameters:
- DEBOUNCE, 8: consecutive cycles of sensors==111 needed to declare a node.
- CROSS_TICKS, 600000: forward-drive cycles after node detect, to centre the axle over the node.
- TURN_WAIT, 16: cycles from `node_changed` pulse to `turn_flag` sampling; covers path_mapping search latency.
- TURN_MIN, 400000: minimum spin cycles for a 90° turn before line reacquire is accepted.
- UTURN_MIN, 900000: minimum spin cycles for a U-turn.
- TURN_MAX, 3000000: spin timeout.
- LOST_TICKS, 1500000: cycles with sensors==000 in FOLLOW before fault.
- CW, 24: width of the shared timer.

Ports:
- clk_3125KHz  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  level; high = run (CPU_start)
- path_len  in  5  number of nodes to traverse
- sensors  in  3  {left, centre, right}; 1 = on line
- turn_flag  in  2  turn code from path_mapping
- node_flag  out  1  one-cycle pulse on node detect
- node_changed  out  1  one-cycle pulse, same cycle as node_flag
- left_dir  out  2  00 stop, 01 fwd, 10 rev
- right_dir  out  2  same encoding
- arrived  out  1  level; high in ARRIVED
- fault  out  1  level; high in FAULT
- node_count  out  5  nodes detected this run

Behaviour:
- Reset: state IDLE; all outputs 0; timer, debounce counter and node_count cleared.
- Only one clock domain; all outputs are registered.
- States: IDLE, FOLLOW, CROSS, WAIT_TURN, SPIN, ARRIVED, FAULT.
- `start`==0 in any state: next cycle IDLE, motors 00, `arrived`/`fault` cleared. node_count holds until the next start.
- IDLE:
  - On `start`==1: node_count<=0 and go to FOLLOW.
  - If `path_len`==0: go straight to ARRIVED.
- FOLLOW steering (registered, applied the cycle after sampling):
  - 010 → both fwd.
  - 100 or 110 → left stop, right fwd.
  - 001 or 011 → left fwd, right stop.
  - 101 → both fwd.
  - 000 → hold last command and run the lost timer. Timer reaches LOST_TICKS → FAULT. Any nonzero sample clears it.
- Node detect:
  - Debounce counter increments while `sensors`==111 and clears otherwise.
  - On reaching DEBOUNCE: `node_flag`=`node_changed`=1 for exactly one cycle, node_count+1 (saturating at 31), go to CROSS.
  - Counter then clears; no retrigger until FOLLOW is re-entered.
- CROSS:
  - Both fwd for CROSS_TICKS cycles.
  - Then if node_count==path_len → ARRIVED, else → WAIT_TURN.
- WAIT_TURN:
  - Motors 00. Timer counts from the `node_changed` cycle.
  - At count==TURN_WAIT (measured from the pulse, which has already elapsed during CROSS when CROSS_TICKS ≥ TURN_WAIT), latch `turn_flag` once.
  - Latched 0 → FOLLOW.
  - 1 → SPIN right (left fwd, right rev).
  - 3 → SPIN left (left rev, right fwd).
  - 2 → SPIN right with UTURN_MIN.
- SPIN:
  - Timer runs from entry.
  - Centre sensor is ignored until timer ≥ TURN_MIN (or UTURN_MIN for U-turn). After that, the first cycle with centre==1 → FOLLOW with both fwd.
  - Timer reaches TURN_MAX → FAULT.
  - `turn_flag` changes during SPIN are ignored.
- ARRIVED: motors 00, `arrived`=1, held until `start` drops.
- FAULT: motors 00, `fault`=1, held until `start` drops or reset.
- Arithmetic:
  - Timer is CW bits and saturates, never wraps.
  - Comparisons are unsigned.
  - node_count compared to `path_len` at full 5-bit width.
- Simultaneous events:
  - `reset` beats `start`; `start`==0 beats everything else.
  - Node detect and lost timeout cannot coincide (111 ≠ 000).
  - TURN_MAX and reacquire in the same cycle → reacquire wins.

Test Plan:
- Reset mid-SPIN: reset=1 for one cycle → next cycle state IDLE, left_dir=right_dir=00, node_count=0, `node_changed`=0.
- Line following: start=1, sensors 010/100/001 → dirs {01,01}/{00,01}/{01,00}, each one cycle after the sample.
- Node detect with DEBOUNCE=8: sensors=111 for 7 cycles then 010 → no pulse. 111 for 8 cycles → single-cycle `node_flag`/`node_changed`, node_count=1, CROSS entered.
- Right turn with small params (CROSS_TICKS=20, TURN_WAIT=16, TURN_MIN=50): turn_flag=1 after pulse → dirs {01,10}. Centre=1 at cycle 30 ignored; centre=1 at cycle 60 → FOLLOW.
- U-turn/timeout: turn_flag=2, centre held 0 for TURN_MAX → `fault`=1, motors 00. Drop start → IDLE, fault=0.
- Arrival: path_len=3, three debounced nodes with turn_flag=0 → after third CROSS, `arrived`=1, motors 00, no WAIT_TURN entry.
